// File: rtl/seq_ab_pkg.sv
// Shared encodings for the A-then-B sequence driver and its downstream detector.
package seq_ab_pkg;
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CLR     = 3'd1;
   localparam logic [2:0] S_SEND_A  = 3'd2;
   localparam logic [2:0] S_GAP     = 3'd3;
   localparam logic [2:0] S_SEND_B  = 3'd4;
   localparam logic [2:0] S_WAIT_OK = 3'd5;
   localparam logic [2:0] S_FINISH  = 3'd6;

   // Detector-side states, kept here so both ends agree on the encoding.
   localparam logic [1:0] D_IDLE     = 2'd0;
   localparam logic [1:0] D_WAITFORB = 2'd1;
   localparam logic [1:0] D_DONE     = 2'd2;
   localparam logic [1:0] D_ERROR    = 2'd3;

   localparam int DEF_TIMEOUT = 8;
endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter that saturates at zero; flags for one and zero.
module seq_down_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] value,
   output logic         is_one,
   output logic         is_zero
);
   always_ff @(posedge clk) begin
      if (rst)
         value <= '0;
      else if (load)
         value <= load_val;
      else if (en && value != '0)
         value <= value - 1'b1;
   end

   assign is_one  = (value == W'(1));
   assign is_zero = (value == '0);
endmodule

// File: rtl/seq_ab_driver.sv
// Drives det_rst/A/gap/B pairs into the sequence detector and checks rx_ok.
module seq_ab_driver
   import seq_ab_pkg::*;
#(
   parameter int GAP_W   = 4,
   parameter int REP_W   = 4,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int TO_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             inject_err,
   input  logic [GAP_W-1:0] gap,
   input  logic [REP_W-1:0] reps,
   input  logic             rx_ok,
   output logic             det_rst,
   output logic             A,
   output logic             B,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [2:0]       stateOut
);
   logic [2:0]       state, nxt;
   logic [GAP_W-1:0] gap_q;
   logic [REP_W-1:0] rem;
   logic             inj_q;
   logic             fail_q;

   logic [GAP_W-1:0] g_val;
   logic [TO_W-1:0]  to_val;
   logic             g_one, g_zero, to_one, to_zero;
   logic             pair_end, pair_fail, more;

   seq_down_counter #(.W(GAP_W)) u_gap (
      .clk(clk), .rst(rst),
      .load(state == S_SEND_A && gap_q != '0), .en(state == S_GAP),
      .load_val(gap_q), .value(g_val), .is_one(g_one), .is_zero(g_zero)
   );

   seq_down_counter #(.W(TO_W)) u_to (
      .clk(clk), .rst(rst),
      .load(state == S_SEND_B), .en(state == S_WAIT_OK),
      .load_val(TO_W'(TIMEOUT)), .value(to_val), .is_one(to_one), .is_zero(to_zero)
   );

   logic unused_cnt;
   assign unused_cnt = ^{g_val, to_val, to_zero};

   // rx_ok takes priority over expiry; in inject mode the sense is inverted.
   assign pair_end  = (state == S_WAIT_OK) && (rx_ok || to_one);
   assign pair_fail = inj_q ? rx_ok : !rx_ok;
   assign more      = (rem > REP_W'(1));

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:    if (start) nxt = S_CLR;
         S_CLR:     nxt = inj_q ? S_SEND_B : S_SEND_A;
         S_SEND_A:  nxt = (gap_q == '0) ? S_SEND_B : S_GAP;
         S_GAP:     if (g_one || g_zero) nxt = S_SEND_B;
         S_SEND_B:  nxt = S_WAIT_OK;
         S_WAIT_OK: if (pair_end) nxt = more ? S_CLR : S_FINISH;
         S_FINISH:  nxt = S_IDLE;
         default:   nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         gap_q  <= '0;
         rem    <= '0;
         inj_q  <= 1'b0;
         fail_q <= 1'b0;
      end else begin
         state <= nxt;
         if (state == S_IDLE && start) begin
            gap_q  <= gap;
            rem    <= (reps == '0) ? REP_W'(1) : reps;
            inj_q  <= inject_err;
            fail_q <= 1'b0;
         end
         if (pair_end && pair_fail) fail_q <= 1'b1;
         if (pair_end && more) rem <= rem - 1'b1;
      end
   end

   assign det_rst  = (state == S_CLR);
   assign A        = (state == S_SEND_A);
   assign B        = (state == S_SEND_B);
   assign busy     = (state != S_IDLE);
   assign done     = (state == S_FINISH);
   assign fail     = fail_q;
   assign stateOut = state;
endmodule
